// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port DMEM arbiter with read-modify-write sub-word stores
//
// Purpose:
//   Shares one 32-bit, big-endian data memory between port 0 (CPU load/store)
//   and port 1 (DMA / debug loader). A single access is in flight at a time.
//   Byte and halfword stores are carried out as read-modify-write.
//
// Configuration:
//   DMEM_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                   undefined -> fixed priority, port 0 wins ties
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   Req0/1              request, held with fields stable until Gnt
//   We0/1               1 = store, 0 = load
//   Size0/1             00 byte, 01 half, 1x word
//   Addr0/1             byte address, any alignment
//   WData0/1            right-justified store data
//   Gnt0/1              one-cycle pulse: request latched
//   Done0/1             one-cycle pulse: access complete
//   RData0/1            zero-extended load data, held until next Done
//   MemAddr/MemDataW    to DMEM Addr/DataW
//   MemRW               to DMEM MemRW (1 = write)
//   MemDataR            from DMEM DataR
//   Busy                high whenever the FSM is not idle

module dmem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Req0,
   input  logic              Req1,
   input  logic              We0,
   input  logic              We1,
   input  logic [1:0]        Size0,
   input  logic [1:0]        Size1,
   input  logic [ADDR_W-1:0] Addr0,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic [31:0]       WData0,
   input  logic [31:0]       WData1,
   output logic              Gnt0,
   output logic              Gnt1,
   output logic              Done0,
   output logic              Done1,
   output logic [31:0]       RData0,
   output logic [31:0]       RData1,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [31:0]       MemDataW,
   output logic              MemRW,
   input  logic [31:0]       MemDataR,
   output logic              Busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_WR,
      ST_DONE
   } state_t;

   state_t state_q, state_d;

   // Latched request. addr_q drives MemAddr and wdata_q drives MemDataW
   // directly; wdata_q is overwritten with the merged word before WR.
   logic              own_q;     // 0 = port 0 owns the access, 1 = port 1
   logic              we_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   // Arbitration
   logic              any_req;
   logic              sel1;
   logic              sel_we;
   logic [1:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;

   assign any_req = Req0 | Req1;

`ifdef DMEM_ARB_RR_EN
   // 1 = port 1 was granted last. Resets to 1 so port 0 takes the first tie.
   logic last_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         last_q <= 1'b1;
      end else if (state_q == ST_IDLE && any_req) begin
         last_q <= sel1;
      end
   end

   assign sel1 = Req1 & (~Req0 | ~last_q);
`else
   assign sel1 = Req1 & ~Req0;
`endif

   assign sel_we    = sel1 ? We1    : We0;
   assign sel_size  = sel1 ? Size1  : Size0;
   assign sel_addr  = sel1 ? Addr1  : Addr0;
   assign sel_wdata = sel1 ? WData1 : WData0;

   // DMEM word is big-endian: the addressed byte sits in [31:24].
   logic [31:0] load_data;
   logic [31:0] merge_data;

   always_comb begin
      load_data  = MemDataR;
      merge_data = wdata_q;
      case (size_q)
         2'b00: begin
            load_data  = {24'h0, MemDataR[31:24]};
            merge_data = {wdata_q[7:0], MemDataR[23:0]};
         end
         2'b01: begin
            load_data  = {16'h0, MemDataR[31:16]};
            merge_data = {wdata_q[15:0], MemDataR[15:0]};
         end
         default: begin
            load_data  = MemDataR;
            merge_data = wdata_q;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and state-decoded outputs
   always_comb begin
      state_d = state_q;
      MemRW   = 1'b0;
      Busy    = 1'b1;
      Done0   = 1'b0;
      Done1   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            Busy = 1'b0;
            if (any_req) begin
               // Only full-word stores skip the read phase.
               state_d = (sel_we && sel_size[1]) ? ST_WR : ST_RD;
            end
         end
         ST_RD: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            state_d = we_q ? ST_WR : ST_DONE;
         end
         ST_WR: begin
            MemRW   = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            Done0   = ~own_q;
            Done1   = own_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request latch, grant pulses, load capture and store merge
   always_ff @(posedge Clk) begin
      if (Rst) begin
         own_q    <= 1'b0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         Gnt0     <= 1'b0;
         Gnt1     <= 1'b0;
         RData0   <= 32'h0;
         RData1   <= 32'h0;
      end else begin
         Gnt0 <= 1'b0;
         Gnt1 <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  own_q   <= sel1;
                  we_q    <= sel_we;
                  size_q  <= sel_size;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  Gnt0    <= ~sel1;
                  Gnt1    <= sel1;
               end
            end
            ST_WAIT: begin
               if (!we_q) begin
                  if (own_q) begin
                     RData1 <= load_data;
                  end else begin
                     RData0 <= load_data;
                  end
               end else begin
                  wdata_q <= merge_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign MemAddr  = addr_q;
   assign MemDataW = wdata_q;

endmodule
